msg_tx_arbiter: RTL
===================

Name: msg_tx_arbiter

Overview:
- Shares one serial transmitter (clk115 domain, sbyte/sbyte_rdy/end_of_send handshake) and one synchronous message ROM between NREQ requesters.
- Each requester supplies a ROM start address. The block fetches and transmits characters from that address up to and including a terminator character.
- Requesters are served round-robin. The block replaces hand-written per-board send state machines in top levels.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, ROM address width.
- ROM_LAT, 2, ROM read latency in cycles from rom_addr change to valid rom_q (1..3).
- TERM, 8'h2A, terminator character; it is transmitted, then the message ends.
- TIMEOUT, 16'd2000, end_of_send watchdog limit in cycles (used only with the optional feature).

Ports:
- clk115, input, 1, system clock (115.2 kHz bit clock domain).
- reset, input, 1, synchronous, active-high.
- req, input, NREQ, per-requester level request; hold high until done.
- req_addr, input, NREQ*AW, start addresses; requester i uses bits [i*AW +: AW].
- grant, output, NREQ, one-hot; the requester currently being served.
- done, output, NREQ, one-cycle pulse on the requester's bit when its terminator has been sent.
- busy, output, 1, high in every state except IDLE.
- rom_addr, output, AW, registered ROM address.
- rom_q, input, 8, ROM data.
- sbyte, output, 8, character to the transmitter; registered.
- sbyte_rdy, output, 1, one-cycle start pulse to the transmitter.
- end_of_send, input, 1, transmitter pulse indicating the character is complete.
- err, output, 1, one-cycle abort pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, any state): state=IDLE, grant=0, done=0, busy=0, rom_addr=0, sbyte=0, sbyte_rdy=0, err=0, rr pointer=0, fetch counter=0. Reset during WAIT_SENT abandons the character. No done is issued.
- States: IDLE, FETCH, SEND, WAIT_SENT, FINISH.
- IDLE: if req!=0, pick the first set bit searching from rr pointer upward, modulo NREQ.
  - Next cycle: grant=onehot(i), rom_addr=req_addr[i], fetch counter=0, state=FETCH.
  - If req==0, stay in IDLE.
- FETCH: count ROM_LAT cycles. On the last one, sbyte<=rom_q and state=SEND.
- SEND: sbyte_rdy=1 for exactly this one cycle, then state=WAIT_SENT.
- WAIT_SENT: hold sbyte and rom_addr stable. On end_of_send:
  - If sbyte==TERM, state=FINISH.
  - Otherwise rom_addr<=rom_addr+1 (mod 2^AW, wraps from all-ones to 0 silently) and state=FETCH.
  - end_of_send seen in any other state is ignored.
- FINISH (one cycle): done[i]=1, grant=0, rr pointer=(i+1) mod NREQ, state=IDLE. The earliest next grant is two cycles after FINISH.
- req is sampled only in IDLE. Dropping req mid-message does not abort; the message completes and done still pulses.
- req_addr is sampled only at grant. Later changes are ignored.
- Per-character cycle count, excluding transmitter time: ROM_LAT + 1 + (wait for end_of_send).
- A simultaneous new request and FINISH: the new request waits for IDLE and is then arbitrated with the updated pointer.
- A requester holding req continuously is re-served only after every other pending requester has been served once.
- No message-length limit; a ROM with no TERM loops indefinitely unless the optional feature is enabled.

Optional Feature:
- Macro: MSG_TX_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to WAIT_SENT and increments each cycle there.
  - Reaching TIMEOUT without end_of_send produces, in the next cycle: err=1 pulse, grant=0, no done, rr pointer advanced past i, state=IDLE.
  - The counter also aborts a message after 2^AW characters with no TERM, with the same err response.
- Without the macro: no counters, err tied 0, WAIT_SENT waits indefinitely.

Test Plan:
- req=4'b0001, req_addr[0]=8'h00, ROM holds "Hi*" at 0..2, end_of_send 10 cycles after each sbyte_rdy -> sbyte pulses 8'h48, 8'h69, 8'h2A; one done[0] pulse; grant=4'b0001 throughout; busy low afterwards.
- req=4'b0101 asserted together after reset -> requester 0 served first, then requester 2. grant never has two bits set. Each requester gets exactly one done.
- req=4'b1111 held permanently, single-character messages -> grant order 0,1,2,3,0,1.
- req_addr=8'hFF, ROM[FF]=8'h41, ROM[00]=8'h2A -> rom_addr wraps FF->00; sends 8'h41 then 8'h2A; done pulses.
- reset asserted for 1 cycle during WAIT_SENT of the second character -> all outputs at reset values next cycle; no done; next request starts from requester 0.
- With MSG_TX_TIMEOUT_EN and TIMEOUT=16'd50, end_of_send never asserted -> err pulses 51 cycles after sbyte_rdy; no done; the next pending requester is granted.

Source files
------------

// File: rtl/msg_tx_arbiter.sv
// msg_tx_arbiter
// ---------------------------------------------------------------------------
// Shares one serial transmitter and one synchronous message ROM between NREQ
// requesters. A granted requester's message is fetched from the ROM starting
// at its start address and sent one character at a time. The message ends
// after the terminator character TERM has been transmitted. Requesters are
// served round-robin.
//
// Optional feature macro: MSG_TX_TIMEOUT_EN
//   When defined, a watchdog aborts a character whose end_of_send never
//   arrives within TIMEOUT cycles. It also aborts a message that runs for
//   2^AW characters without a terminator. An abort pulses err and produces
//   no done. When undefined, err is tied low and WAIT_SENT waits forever.
//
// Ports
//   clk115      : system clock (115.2 kHz bit clock domain)
//   reset       : synchronous, active-high
//   req         : per-requester level request, held until its done pulse
//   req_addr    : start addresses, requester i uses [i*AW +: AW]
//   grant       : one-hot, the requester currently being served
//   done        : one-cycle pulse on the requester's bit after its terminator
//   busy        : high whenever the controller is not idle
//   rom_addr    : registered ROM address
//   rom_q       : ROM read data, ROM_LAT cycles after rom_addr changes
//   sbyte       : registered character for the transmitter
//   sbyte_rdy   : one-cycle start pulse for the transmitter
//   end_of_send : transmitter pulse, current character complete
//   err         : one-cycle abort pulse (watchdog build only)
// ---------------------------------------------------------------------------
module msg_tx_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          AW      = 8,
  parameter int          ROM_LAT = 2,
  parameter logic [7:0]  TERM    = 8'h2A,
  parameter logic [15:0] TIMEOUT = 16'd2000
) (
  input  logic              clk115,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [AW-1:0]     rom_addr,
  input  logic [7:0]        rom_q,
  output logic [7:0]        sbyte,
  output logic              sbyte_rdy,
  input  logic              end_of_send,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_SENT,
    FINISH
  } state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_n, done_n;
  logic [AW-1:0]     rom_addr_n;
  logic [7:0]        sbyte_n;
  logic              sbyte_rdy_n;
  logic [IW-1:0]     rr_ptr, rr_n;
  logic [IW-1:0]     cur_idx, cur_n;
  logic [1:0]        fetch_cnt, fetch_n;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     rr_after;
  int                cand;
  logic [IW-1:0]     cand_idx;

`ifdef MSG_TX_TIMEOUT_EN
  logic              err_r, err_n;
  logic [15:0]       wait_cnt, wait_n;
  logic [AW-1:0]     char_cnt, chars_n;
`endif

  assign busy = (state != IDLE);

  // Round-robin pick: the first requesting index at or above the pointer,
  // wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // After a message ends, normally or by abort, the pointer moves just past
  // the requester that was served. A continuously requesting port therefore
  // goes to the back of the line.
  always_comb begin
    rr_after = (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;
  end

  // Next-state and next-output logic. Outputs are registered. Each pulse
  // (sbyte_rdy, done, err) is set on the transition into the cycle where it
  // must be visible, and it falls back to zero by default.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    done_n      = '0;
    rom_addr_n  = rom_addr;
    sbyte_n     = sbyte;
    sbyte_rdy_n = 1'b0;
    rr_n        = rr_ptr;
    cur_n       = cur_idx;
    fetch_n     = fetch_cnt;
`ifdef MSG_TX_TIMEOUT_EN
    err_n       = 1'b0;
    wait_n      = wait_cnt;
    chars_n     = char_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n           = FETCH;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          rom_addr_n        = req_addr[int'(pick_idx)*AW +: AW];
          cur_n             = pick_idx;
          fetch_n           = '0;
`ifdef MSG_TX_TIMEOUT_EN
          chars_n           = '0;
`endif
        end
      end

      // rom_q is captured on the closing edge of the ROM_LAT-th fetch cycle.
      FETCH: begin
        if (fetch_cnt == 2'(ROM_LAT - 1)) begin
          sbyte_n     = rom_q;
          sbyte_rdy_n = 1'b1;
          fetch_n     = '0;
          state_n     = SEND;
`ifdef MSG_TX_TIMEOUT_EN
          wait_n      = '0;
`endif
        end else begin
          fetch_n = fetch_cnt + 2'd1;
        end
      end

      SEND: begin
        state_n = WAIT_SENT;
      end

      // sbyte and rom_addr stay untouched here until the transmitter
      // reports completion.
      WAIT_SENT: begin
        if (end_of_send) begin
          if (sbyte == TERM) begin
            state_n         = FINISH;
            done_n[cur_idx] = 1'b1;
            grant_n         = '0;
            rr_n            = rr_after;
          end
`ifdef MSG_TX_TIMEOUT_EN
          else if (&char_cnt) begin
            err_n   = 1'b1;
            grant_n = '0;
            rr_n    = rr_after;
            state_n = IDLE;
          end
`endif
          else begin
            rom_addr_n = rom_addr + 1'b1;
            fetch_n    = '0;
            state_n    = FETCH;
`ifdef MSG_TX_TIMEOUT_EN
            chars_n    = char_cnt + 1'b1;
`endif
          end
        end
`ifdef MSG_TX_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT - 16'd1) begin
          err_n   = 1'b1;
          grant_n = '0;
          rr_n    = rr_after;
          state_n = IDLE;
        end else begin
          wait_n = wait_cnt + 16'd1;
        end
`endif
      end

      FINISH: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State and output registers. Reset abandons any character in flight
  // without signalling done.
  always_ff @(posedge clk115) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      rom_addr  <= '0;
      sbyte     <= '0;
      sbyte_rdy <= 1'b0;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      done      <= done_n;
      rom_addr  <= rom_addr_n;
      sbyte     <= sbyte_n;
      sbyte_rdy <= sbyte_rdy_n;
      rr_ptr    <= rr_n;
      cur_idx   <= cur_n;
      fetch_cnt <= fetch_n;
    end
  end

`ifdef MSG_TX_TIMEOUT_EN
  // Watchdog registers: the per-character wait counter, the per-message
  // character counter and the abort pulse.
  always_ff @(posedge clk115) begin
    if (reset) begin
      err_r    <= 1'b0;
      wait_cnt <= '0;
      char_cnt <= '0;
    end else begin
      err_r    <= err_n;
      wait_cnt <= wait_n;
      char_cnt <= chars_n;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
